// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge
//   Byte-serial memory bridge between the CPU core and the external Arduino.
//   Takes one 16-bit FETCH/LOAD/STORE request, sends it as a byte frame,
//   collects the reply bytes and returns a 16-bit word or an error.
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   req_valid/ready    request handshake (ready only in IDLE)
//   req_op/addr/wdata  request opcode, word address, store data
//   resp_valid         one-cycle response pulse
//   resp_data/error    response word and error flag (held until next response)
//   out_bus            outgoing byte, qualified by data_out_ready
//   ard_receive_ready  Arduino accepts out_bus this cycle
//   in_bus             incoming byte, qualified by ard_data_ready
//   in_ack             bridge consumes in_bus this cycle
module mem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  STATUS_OK      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_error,
  output logic [7:0]  out_bus,
  output logic        data_out_ready,
  input  logic        ard_receive_ready,
  input  logic [7:0]  in_bus,
  input  logic        ard_data_ready,
  output logic        in_ack
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
  // Abort once the stalled cycle would bring the counter to TIMEOUT_CYCLES-1.
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, SEND, RECV, RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic [15:0]       addr_q, wdata_q;
  logic [2:0]        idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic accept, tx_fire, rx_fire, stalled, timeout, is_store, last_tx;

  assign accept   = req_valid && (state_q == IDLE);
  assign tx_fire  = (state_q == SEND) && ard_receive_ready;
  assign rx_fire  = (state_q == RECV) && ard_data_ready;
  assign stalled  = ((state_q == SEND) && !ard_receive_ready) ||
                    ((state_q == RECV) && !ard_data_ready);
  assign timeout  = stalled && (wait_q == WAIT_LIMIT);
  assign is_store = (op_q == 2'b10);
  assign last_tx  = (idx_q == (is_store ? 3'd4 : 3'd2));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      hi_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      hi_q    <= hi_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    hi_d    = hi_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d  = '0;
          wait_d = '0;
          if (req_op == 2'b11) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        // A transfer in the limit cycle takes priority over the timeout.
        if (tx_fire) begin
          wait_d = '0;
          if (last_tx) begin
            state_d = RECV;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (timeout) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RECV: begin
        if (rx_fire) begin
          wait_d = '0;
          if (is_store) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = (in_bus != STATUS_OK);
          end else if (idx_q == 3'd0) begin
            hi_d  = in_bus;
            idx_d = 3'd1;
          end else begin
            state_d = RESP;
            rdata_d = {hi_q, in_bus};
            err_d   = 1'b0;
          end
        end else if (timeout) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready      = (state_q == IDLE);
    data_out_ready = (state_q == SEND);
    in_ack         = (state_q == RECV);
    resp_valid     = (state_q == RESP);
    resp_data      = rdata_q;
    resp_error     = err_q;
    out_bus        = 8'h00;
    if (state_q == SEND) begin
      case (idx_q)
        3'd0:    out_bus = {6'b0, op_q};
        3'd1:    out_bus = addr_q[15:8];
        3'd2:    out_bus = addr_q[7:0];
        3'd3:    out_bus = wdata_q[15:8];
        3'd4:    out_bus = wdata_q[7:0];
        default: out_bus = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge
//   Drives mem_bus_bridge with directed and randomized transactions, plays
//   the Arduino side, and compares frames and responses against a
//   transaction-level model of the protocol.
module tb_mem_bus_bridge;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_error;
  logic [7:0]  out_bus;
  logic        data_out_ready;
  logic        ard_receive_ready;
  logic [7:0]  in_bus;
  logic        ard_data_ready;
  logic        in_ack;

  mem_bus_bridge #(.TIMEOUT_CYCLES(TMO), .STATUS_OK(8'hA5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .out_bus(out_bus), .data_out_ready(data_out_ready),
    .ard_receive_ready(ard_receive_ready), .in_bus(in_bus),
    .ard_data_ready(ard_data_ready), .in_ack(in_ack)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  int          resp_cyc;
  int          last_tx_cyc;
  logic [15:0] obs_data;
  logic        obs_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction: request, Arduino emulation with random stalls in
  // [slo,shi] per byte, reply bytes r0/r1 (r0 is the status for STORE).
  // no_rx keeps ard_data_ready low so the receive phase must time out.
  task automatic run_txn(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [7:0] r0, input logic [7:0] r1,
                         input int slo, input int shi, input bit no_rx);
    logic [7:0]  seen[$];
    logic [7:0]  expf[$];
    logic [7:0]  rx[2];
    logic [7:0]  held;
    logic [15:0] exp_data;
    logic        exp_err;
    logic [63:0] seen_v, exp_v;
    bit          holding, got, excl_bad, stable_bad;
    int          cyc, stall, rx_i;

    // Reference frame and response from the protocol rules.
    if (op != 2'b11) begin
      expf.push_back({6'b0, op});
      expf.push_back(addr[15:8]);
      expf.push_back(addr[7:0]);
      if (op == 2'b10) begin
        expf.push_back(wdata[15:8]);
        expf.push_back(wdata[7:0]);
      end
    end
    if (op == 2'b11 || no_rx) begin
      exp_data = 16'h0;  exp_err = 1'b1;
    end else if (op == 2'b10) begin
      exp_data = 16'h0;  exp_err = (r0 != 8'hA5);
    end else begin
      exp_data = {r0, r1}; exp_err = 1'b0;
    end

    for (int i = 0; i < 10 && !req_ready; i++) step();
    chk("req_ready_before_accept", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0; req_op = 2'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);

    rx[0] = r0; rx[1] = r1; rx_i = 0;
    cyc = 1; got = 0; holding = 0; excl_bad = 0; stable_bad = 0;
    last_tx_cyc = -1; resp_cyc = -1;
    stall = $urandom_range(shi, slo);
    while (!got && cyc < 200) begin
      if (data_out_ready && in_ack) excl_bad = 1;
      ard_receive_ready = 1'b0;
      ard_data_ready    = 1'b0;
      in_bus            = 8'($urandom);
      if (resp_valid) begin
        got = 1; resp_cyc = cyc; obs_data = resp_data; obs_err = resp_error;
      end else begin
        if (data_out_ready) begin
          if (holding && out_bus !== held) stable_bad = 1;
          if (stall > 0) begin
            stall--; holding = 1; held = out_bus;
          end else begin
            ard_receive_ready = 1'b1;
            seen.push_back(out_bus);
            last_tx_cyc = cyc; holding = 0;
            stall = $urandom_range(shi, slo);
          end
        end
        if (in_ack && !no_rx) begin
          if (stall > 0) stall--;
          else begin
            ard_data_ready = 1'b1;
            in_bus = rx[rx_i & 1];
            rx_i++;
            stall = $urandom_range(shi, slo);
          end
        end
        step();
        cyc++;
      end
    end
    ard_receive_ready = 1'b0;
    ard_data_ready    = 1'b0;

    seen_v = '0; exp_v = '0;
    foreach (seen[i]) seen_v = {seen_v[55:0], seen[i]};
    foreach (expf[i]) exp_v  = {exp_v[55:0], expf[i]};
    chk("resp_seen", got, 1);
    chk("tx_count", seen.size(), expf.size());
    chk("tx_frame", seen_v, exp_v);
    chk("resp_data", obs_data, exp_data);
    chk("resp_error", obs_err, exp_err);
    chk("dor_inack_exclusive", excl_bad, 0);
    chk("out_bus_stable", stable_bad, 0);
  endtask

  initial begin
    bit spurious;
    logic [1:0] rop;

    rst = 1'b0;
    req_valid = 1'b0; req_op = 2'b00; req_addr = 16'h0; req_wdata = 16'h0;
    ard_receive_ready = 1'b0; ard_data_ready = 1'b0; in_bus = 8'h00;
    step(); step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outs", {resp_valid, resp_error, data_out_ready, in_ack}, 4'b0);
    chk("rst_out_bus", out_bus, 8'h00);
    chk("rst_resp_data", resp_data, 16'h0);
    rst = 1'b1;
    step();

    // LOAD, zero wait.
    run_txn(2'b01, 16'h1234, 16'h0, 8'hBE, 8'hEF, 0, 0, 0);
    chk("load_resp_cycle", resp_cyc, 6);
    chk("load_last_tx_cycle", last_tx_cyc, 3);
    step(); step();
    chk("resp_data_held", resp_data, 16'hBEEF);
    chk("resp_valid_pulse", resp_valid, 0);

    // STORE good and bad status.
    run_txn(2'b10, 16'h00F0, 16'hCAFE, 8'hA5, 8'h00, 0, 0, 0);
    chk("store_resp_cycle", resp_cyc, 7);
    run_txn(2'b10, 16'h00F0, 16'hCAFE, 8'h5A, 8'h00, 0, 0, 0);

    // FETCH with three stall cycles before every byte.
    run_txn(2'b00, 16'hA55A, 16'h0, 8'h12, 8'h34, 3, 3, 0);

    // Receive never offered: timeout TMO cycles after the last TX byte.
    run_txn(2'b01, 16'h4321, 16'h0, 8'h00, 8'h00, 0, 0, 1);
    chk("timeout_delay", resp_cyc - last_tx_cyc, TMO);

    // Reserved opcode.
    run_txn(2'b11, 16'hFFFF, 16'hFFFF, 8'h00, 8'h00, 0, 0, 0);
    chk("reserved_resp_cycle", resp_cyc, 1);

    // Reset in the middle of SEND.
    run_txn(2'b00, 16'h0102, 16'h0, 8'h77, 8'h88, 0, 0, 0);
    step();
    req_valid = 1'b1; req_op = 2'b01; req_addr = 16'h5555;
    step();
    req_valid = 1'b0;
    step(); step();
    chk("stalled_in_send", data_out_ready, 1);
    rst = 1'b0;
    #1;
    chk("midrst_outs", {resp_valid, resp_error, data_out_ready, in_ack}, 4'b0);
    chk("midrst_bus_data", {out_bus, resp_data}, 24'h0);
    chk("midrst_req_ready", req_ready, 1);
    step();
    rst = 1'b1;
    spurious = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid || data_out_ready) spurious = 1;
      step();
    end
    chk("no_resp_after_rst", spurious, 0);
    run_txn(2'b01, 16'h2468, 16'h0, 8'h13, 8'h57, 0, 1, 0);

    // Randomized transactions.
    for (int n = 0; n < 16; n++) begin
      rop = ($urandom_range(7, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
      run_txn(rop, 16'($urandom), 16'($urandom),
              ($urandom_range(1, 0) == 1) ? 8'hA5 : 8'($urandom), 8'($urandom),
              0, 3, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
